// File: rtl/dct_1d_pipe.sv
// dct_1d_pipe: 3-stage pipelined 8-point 1-D forward DCT with valid/ready flow control,
// configurable widths, optional level shift, rounding and output saturation.
module dct_1d_pipe #(
    parameter int IN_W        = 8,
    parameter int SIGNED_IN   = 0,
    parameter int LEVEL_SHIFT = 0,
    parameter int OUT_W       = 10,
    parameter int SHIFT       = 9,
    parameter int ROUND       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*IN_W-1:0]    data_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*OUT_W-1:0]   data_out,
    output logic                 sat_flag
);
    localparam int AW = IN_W + 14;
    typedef logic signed [AW-1:0] acc_t;

    localparam acc_t C2   = acc_t'(237);
    localparam acc_t C4   = acc_t'(181);
    localparam acc_t C6   = acc_t'(98);
    localparam acc_t CO [4] = '{acc_t'(251), acc_t'(213), acc_t'(142), acc_t'(50)};
    localparam acc_t RND  = (ROUND != 0) ? (acc_t'(1) <<< (SHIFT - 1)) : acc_t'(0);
    localparam acc_t LS   = (LEVEL_SHIFT != 0) ? (acc_t'(1) <<< (IN_W - 1)) : acc_t'(0);
    localparam acc_t ZMAX = acc_t'((1 << (OUT_W - 1)) - 1);
    localparam acc_t ZMIN = -ZMAX - acc_t'(1);

    logic en, v1, v2;
    acc_t x [8];
    acc_t s [4];
    acc_t d [4];
    acc_t e [4];
    acc_t p0, p1, p22, p26, p32, p36;
    acc_t pd [4][4];
    acc_t z [8];
    acc_t q [8];
    acc_t y [8];
    logic [7:0] clip;
    logic [8*OUT_W-1:0] dn;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            x[i] = (SIGNED_IN != 0) ? acc_t'(signed'(data_in[(7-i)*IN_W +: IN_W]))
                                    : acc_t'(data_in[(7-i)*IN_W +: IN_W]);
            x[i] = x[i] - LS;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                s[i] <= x[i] + x[7-i];
                d[i] <= x[i] - x[7-i];
            end
        end
    end

    assign e[0] = s[0] + s[3];
    assign e[1] = s[1] + s[2];
    assign e[2] = s[0] - s[3];
    assign e[3] = s[1] - s[2];

    // pd[i][k] holds c(2k+1) * d_i
    always_ff @(posedge clk) begin
        if (en) begin
            p0  <= C4 * e[0];
            p1  <= C4 * e[1];
            p22 <= C2 * e[2];
            p26 <= C6 * e[2];
            p32 <= C2 * e[3];
            p36 <= C6 * e[3];
            for (int i = 0; i < 4; i++)
                for (int k = 0; k < 4; k++)
                    pd[i][k] <= CO[k] * d[i];
        end
    end

    always_comb begin
        z[0] = p0 + p1;
        z[4] = p0 - p1;
        z[2] = p22 + p36;
        z[6] = p26 - p32;
        z[1] = pd[0][0] + pd[1][1] + pd[2][2] + pd[3][3];
        z[3] = pd[0][1] - pd[1][3] - pd[2][0] - pd[3][2];
        z[5] = pd[0][2] - pd[1][0] + pd[2][3] + pd[3][1];
        z[7] = pd[0][3] - pd[1][2] + pd[2][1] - pd[3][0];
    end

    always_comb begin
        dn   = '0;
        clip = '0;
        for (int k = 0; k < 8; k++) begin
            q[k]    = (z[k] + RND) >>> SHIFT;
            clip[k] = (q[k] > ZMAX) || (q[k] < ZMIN);
            y[k]    = (q[k] > ZMAX) ? ZMAX : (q[k] < ZMIN) ? ZMIN : q[k];
            dn[(7-k)*OUT_W +: OUT_W] = y[k][OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            sat_flag  <= 1'b0;
        end else if (en) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            data_out  <= dn;
            sat_flag  <= |clip;
        end
    end
endmodule

// File: tb/tb_dct_1d_pipe.sv
// tb_dct_1d_pipe: randomized and directed checks of dct_1d_pipe against a
// cosine-matrix reference model with a latency-aware scoreboard.
module tb_dct_1d_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, out_ready = 1'b1;
    logic [63:0] data_in = '0;
    logic in_ready, out_valid, sat_flag;
    logic [79:0] data_out;

    logic a_valid = 1'b0, one = 1'b1;
    logic [63:0] a_data = '0;
    logic ls_ready, ls_valid, ls_sat, o8_ready, o8_valid, o8_sat;
    logic [79:0] ls_data;
    logic [63:0] o8_data;

    always #5 clk = ~clk;

    dct_1d_pipe u_dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .sat_flag(sat_flag));

    dct_1d_pipe #(.LEVEL_SHIFT(1)) u_ls (.clk(clk), .rst(rst), .in_valid(a_valid),
        .in_ready(ls_ready), .data_in(a_data), .out_valid(ls_valid), .out_ready(one),
        .data_out(ls_data), .sat_flag(ls_sat));

    dct_1d_pipe #(.OUT_W(8)) u_o8 (.clk(clk), .rst(rst), .in_valid(a_valid),
        .in_ready(o8_ready), .data_in(a_data), .out_valid(o8_valid), .out_ready(one),
        .data_out(o8_data), .sat_flag(o8_sat));

    typedef struct {
        logic [80:0] r;
        int          c;
        int          st;
    } exp_t;

    exp_t        q[$];
    int          tests = 0, fails = 0;
    int          cyc_n = 0, stalls = 0, popped = 0;
    logic        held = 1'b0;
    logic [80:0] held_data;
    logic [79:0] last_out;

    // Z_k = sum_n x_n * 256*cos((2n+1)k*pi/16), row 0 scaled by 1/sqrt2
    function automatic int cf(input int k, input int n);
        int ctab[9] = '{256, 251, 237, 213, 181, 142, 98, 50, 0};
        int m, sg;
        if (k == 0) return 181;
        m  = ((2*n + 1) * k) % 32;
        sg = 1;
        if (m > 16) m = 32 - m;
        if (m > 8) begin
            m  = 16 - m;
            sg = -1;
        end
        return sg * ctab[m];
    endfunction

    function automatic logic [80:0] model(input logic [63:0] din, input int ls, input int ow);
        int x[8];
        int acc, zz, hi, lo;
        logic [80:0] r;
        r  = '0;
        hi = (1 << (ow - 1)) - 1;
        lo = -hi - 1;
        for (int n = 0; n < 8; n++) x[n] = int'(din[(7-n)*8 +: 8]) - (ls != 0 ? 128 : 0);
        for (int k = 0; k < 8; k++) begin
            acc = 0;
            for (int n = 0; n < 8; n++) acc += x[n] * cf(k, n);
            zz = (acc + 256) >>> 9;
            if (zz > hi) begin zz = hi; r[80] = 1'b1; end
            if (zz < lo) begin zz = lo; r[80] = 1'b1; end
            for (int b = 0; b < ow; b++) r[(7-k)*ow + b] = zz[b];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic iv, input logic [63:0] din, input logic ordy, input logic r);
        exp_t e;
        in_valid  = iv;
        data_in   = din;
        out_ready = ordy;
        rst       = r;
        @(negedge clk);
        if (!r) begin
            if (held) chk("stall_stable", {sat_flag, data_out}, held_data);
            held = out_valid && !out_ready;
            if (held) begin
                held_data = {sat_flag, data_out};
                chk("stall_in_ready", in_ready, 0);
            end
            if (out_valid && out_ready) begin
                tests++;
                assert (q.size() > 0) else begin
                    fails++;
                    $error("FAIL unexpected_block: observed %0h expected none", data_out);
                end
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("data_out", data_out, e.r[79:0]);
                    chk("sat_flag", sat_flag, e.r[80]);
                    chk("latency", cyc_n, e.c + 3 + stalls - e.st);
                    popped++;
                end
                last_out = data_out;
            end
            if (iv && in_ready) begin
                e.r  = model(din, 0, 10);
                e.c  = cyc_n;
                e.st = stalls;
                q.push_back(e);
            end
            if (out_valid && !out_ready) stalls++;
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (r) begin
            q.delete();
            held = 1'b0;
        end
    endtask

    task automatic aux_blk(input logic [63:0] v);
        logic [80:0] el, eo;
        el = model(v, 1, 10);
        eo = model(v, 0, 8);
        a_valid = 1'b1;
        a_data  = v;
        @(posedge clk); #1;
        a_valid = 1'b0;
        a_data  = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ls_valid", ls_valid, 1);
        chk("ls_data", ls_data, el[79:0]);
        chk("ls_sat", ls_sat, el[80]);
        chk("o8_valid", o8_valid, 1);
        chk("o8_data", o8_data, eo[63:0]);
        chk("o8_sat", o8_sat, eo[80]);
    endtask

    initial begin
        logic [63:0] v;
        int idx, st0, p0;
        @(posedge clk); #1;
        step(0, '0, 1, 1);
        step(0, '0, 1, 1);
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_data_out", data_out, 0);
        chk("rst_sat", sat_flag, 0);

        step(1, {8'd100, 56'd0}, 1, 0);
        for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
        chk("impulse", last_out, {10'd35, 10'd49, 10'd46, 10'd42, 10'd35, 10'd28, 10'd19, 10'd10});

        step(1, {8{8'd255}}, 1, 0);
        step(1, '0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, '0, 1, 0);

        aux_blk({8{8'd128}});
        aux_blk('0);
        aux_blk({8{8'd255}});
        aux_blk('0);

        for (int i = 0; i < 30; i++)
            step($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 3) != 0, 0);
        for (int i = 0; i < 8; i++) step(0, '0, 1, 0);

        idx = 0;
        st0 = -1;
        p0  = popped;
        for (int c = 0; c < 40; c++) begin
            if (out_valid && st0 < 0) st0 = c;
            v = {$urandom, 24'($urandom), 8'(idx)};
            step(idx < 6, v, !(st0 >= 0 && c < st0 + 5), 0);
            if (in_valid && in_ready) idx++;
        end
        chk("bp_count", popped - p0, 6);
        chk("bp_empty", q.size(), 0);

        for (int i = 0; i < 3; i++) step(1, {$urandom, $urandom}, 1, 0);
        step(1, {$urandom, $urandom}, 0, 1);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_sat", sat_flag, 0);
        for (int i = 0; i < 5; i++) step(0, '0, 1, 0);
        p0 = popped;
        step(1, {$urandom, $urandom}, 1, 0);
        for (int i = 0; i < 5; i++) step(0, '0, 1, 0);
        chk("post_rst_count", popped - p0, 1);
        chk("final_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dct_1d_pipe.md
# dct_1d_pipe

Pipelined, parametrised 8-point 1-D forward DCT with valid/ready flow control. It is the successor of the team's combinational 8-point DCT. It adds configurable input/output widths, signed or unsigned input with optional level shift, selectable rounding, output saturation with a flag, and a 3-stage registered datapath that accepts one 8-sample block per cycle. It sits between the block/row buffer and the transpose memory of the 2-D DCT path, and is instantiated once for rows and once for columns.

## Interface
- `IN_W`, 8: bits per input sample.
- `SIGNED_IN`, 0: 1 means samples are two's complement; 0 means unsigned.
- `LEVEL_SHIFT`, 0: 1 subtracts 2^(IN_W-1) from every sample before the transform. Legal only with `SIGNED_IN`=0.
- `OUT_W`, 10: bits per output coefficient, signed.
- `SHIFT`, 9: right shift applied to the full-precision sum.
- `ROUND`, 1: 1 adds 2^(SHIFT-1) before the shift; 0 truncates with a floor shift.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `data_in` holds a block.
- `in_ready` out 1: block accepted on a cycle where `in_valid && in_ready`.
- `data_in` in 8*IN_W: x0 in the top IN_W bits, x7 in the bottom IN_W bits.
- `out_valid` out 1: `data_out` holds a result block.
- `out_ready` in 1: downstream accepts on a cycle where `out_valid && out_ready`.
- `data_out` out 8*OUT_W: z0 in the top OUT_W bits, z7 in the bottom OUT_W bits.
- `sat_flag` out 1: at least one of z0..z7 in the current output block was clipped.

## Operation
- Coefficients are fixed 8-bit unsigned: c1=251, c2=237, c3=213, c4=181, c5=142, c6=98, c7=50.
- Sample extension:
  - Each sample is extended to a signed value of IN_W+1 bits: zero-extended if `SIGNED_IN`=0, sign-extended otherwise.
  - If `LEVEL_SHIFT`=1, 2^(IN_W-1) is then subtracted.
- Stage 1, butterfly. For i=0..3:
  - s_i = x_i + x_{7-i}
  - d_i = x_i - x_{7-i}
- Stage 2, even/odd split and products:
  - e0 = s0+s3, e1 = s1+s2, e2 = s0-s3, e3 = s1-s2.
  - Register every product c·e and c·d needed below.
- Stage 3, sums:
  - Z0 = c4(e0+e1)
  - Z4 = c4(e0-e1)
  - Z2 = c2·e2 + c6·e3
  - Z6 = c6·e2 - c2·e3
  - Z1 = c1d0 + c3d1 + c5d2 + c7d3
  - Z3 = c3d0 - c7d1 - c1d2 - c5d3
  - Z5 = c5d0 - c1d1 + c7d2 + c3d3
  - Z7 = c7d0 - c5d1 + c3d2 - c1d3
- Output scaling:
  - z_k = (Z_k + (ROUND ? 2^(SHIFT-1) : 0)) >>> SHIFT, using an arithmetic shift.
  - Each z_k is then saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Widths:
  - All intermediates are signed.
  - The accumulator width is IN_W+14. No intermediate overflow is permitted for any input.
- `sat_flag` is the OR of the per-coefficient clip conditions for the same block. It is aligned with `data_out`.

## Timing
- Each of the 3 pipeline stages has a data register and a valid bit.
- Global enable: `en = !out_valid || out_ready`.
  - When `en`=1, all stages advance together.
  - When `en`=0, all stage registers hold.
- `in_ready = en`. This is combinational from `out_valid` and `out_ready`.
- Latency: a block accepted at edge N appears with `out_valid`=1 after edge N+3, provided `en` stays high.
- Throughput is 1 block per cycle.
- Bubbles are not collapsed: an empty stage still occupies its slot.
- While `out_valid && !out_ready`:
  - `data_out` and `sat_flag` must stay stable.
  - `in_ready`=0.
  - No block may be lost or duplicated.
- A block with `in_valid`=0 on an enabled edge inserts a bubble with valid=0. Its data contents are don't-care.
- Reset:
  - On any edge with `rst`=1, all stage valid bits clear. Any in-flight blocks, including ones mid-pipeline, are dropped.
  - After reset: `out_valid`=0, `in_ready`=1, `data_out`=0, `sat_flag`=0.
  - `rst` takes priority over a simultaneous handshake; the input block offered on that edge is not accepted.
- On `in_valid && in_ready` while `out_valid && out_ready` in the same cycle, both transfers occur.

## Test plan
- Defaults, x0=100 and x1..x7=0 → z = {35, 49, 46, 42, 35, 28, 19, 10}, `sat_flag`=0, 3 cycles after acceptance.
- Defaults, all samples 255 → z0=721, z1..z7=0, `sat_flag`=0.
- `LEVEL_SHIFT`=1, all samples 128 → all z=0. Same configuration, all samples 0 → z0=-362, z1..z7=0.
- `OUT_W`=8, all samples 255 → z0=127, `sat_flag`=1. Next block all 0 → `sat_flag`=0.
- Backpressure:
  - Stimulus: stream 6 distinct blocks back to back, holding `out_ready`=0 for 5 cycles from the first `out_valid`.
  - Required: `in_ready`=0 throughout the stall; `data_out` stable; all 6 blocks emerge in order, each exactly once.
- Reset mid-stream:
  - Stimulus: assert `rst` for 1 cycle with 3 blocks in flight.
  - Required: the next cycle shows `out_valid`=0 and `in_ready`=1; no dropped block ever appears; a block sent afterwards emerges after 3 cycles.
